// File: rtl/pipe_ctrl.sv
// Control and hazard unit for a classic 5-stage pipeline: decodes the ID instruction,
// carries control bundles through ID/EX, EX/MEM and MEM/WB, and resolves stalls, flushes and forwarding.
module pipe_ctrl #(
    parameter int RA_W    = 5,
    parameter int FWD_EN  = 1,
    parameter int ADDI_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      opcode,
    input  logic [5:0]      func,
    input  logic [RA_W-1:0] rs,
    input  logic [RA_W-1:0] rt,
    input  logic [RA_W-1:0] rd,
    input  logic            equal,
    input  logic            notEqual,
    output logic            stall,
    output logic            flush,
    output logic [1:0]      PCsrc,
    output logic [2:0]      ex_ALUop,
    output logic            ex_ALUsrc,
    output logic            ex_regDest,
    output logic [1:0]      fwdA,
    output logic [1:0]      fwdB,
    output logic            mem_memRead,
    output logic            mem_memWrite,
    output logic            wb_regWrite,
    output logic            wb_memToReg,
    output logic [RA_W-1:0] wb_dst,
    output logic            illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_NOP = 3'd7;

    typedef struct packed {
        logic [2:0]      alu_op;
        logic            alu_src;
        logic            reg_dest;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            mem_to_reg;
        logic            illegal;
        logic [RA_W-1:0] dst;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
    } bundle_t;

    localparam bundle_t BUBBLE = '{alu_op: ALU_NOP, default: '0};

    bundle_t stage_reg  [3];
    bundle_t stage_next [3];
    bundle_t dec;
    bundle_t ex_b, mem_b, wb_b;

    logic uses_rs, uses_rt, is_beq, is_bne, is_j;
    logic ex_writes, mem_writes, wb_writes;
    logic ex_src_hit, mem_src_hit;
    logic load_use, branch_haz, nofwd_haz;
    logic unused_bits;

    // ---------------- ID decode ----------------
    always_comb begin
        dec     = BUBBLE;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec.reg_dest  = 1'b1;
                dec.reg_write = 1'b1;
                dec.dst       = rd;
                dec.rs        = rs;
                dec.rt        = rt;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
                case (func)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    default: begin
                        dec.alu_op    = ALU_NOP;
                        dec.reg_write = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                dec.alu_op     = ALU_ADD;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.dst        = rt;
                dec.rs         = rs;
                dec.rt         = rt;
                uses_rs        = 1'b1;
            end
            OP_SW: begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.rs        = rs;
                dec.rt        = rt;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_ADDI: begin
                if (ADDI_EN != 0) begin
                    dec.alu_op    = ALU_ADD;
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.dst       = rt;
                    dec.rs        = rs;
                    dec.rt        = rt;
                    uses_rs       = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_BEQ, OP_BNE: begin
                dec.rs  = rs;
                dec.rt  = rt;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                is_beq  = (opcode == OP_BEQ);
                is_bne  = (opcode == OP_BNE);
            end
            OP_J: begin
                dec.rs = rs;
                dec.rt = rt;
                is_j   = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // ---------------- hazard detection ----------------
    assign ex_b  = stage_reg[0];
    assign mem_b = stage_reg[1];
    assign wb_b  = stage_reg[2];

    // Register 0 is hard-wired, so a zero destination never produces a value.
    assign ex_writes  = ex_b.reg_write  && (ex_b.dst  != '0);
    assign mem_writes = mem_b.reg_write && (mem_b.dst != '0);
    assign wb_writes  = wb_b.reg_write  && (wb_b.dst  != '0);

    assign ex_src_hit  = ex_writes  && ((uses_rs && ex_b.dst  == rs) || (uses_rt && ex_b.dst  == rt));
    assign mem_src_hit = mem_writes && ((uses_rs && mem_b.dst == rs) || (uses_rt && mem_b.dst == rt));

    assign load_use   = ex_b.mem_read && ex_src_hit;
    // Branches compare in ID, so they need the value one stage earlier than the ALU does.
    assign branch_haz = (is_beq || is_bne) && (ex_src_hit || (mem_b.mem_read && mem_src_hit));
    assign nofwd_haz  = (FWD_EN == 0) && (ex_src_hit || mem_src_hit);

    assign stall = load_use || branch_haz || nofwd_haz;

    always_comb begin
        PCsrc = 2'd0;
        flush = 1'b0;
        if (!stall) begin
            if ((is_beq && equal) || (is_bne && notEqual)) begin
                PCsrc = 2'd1;
                flush = 1'b1;
            end else if (is_j) begin
                PCsrc = 2'd2;
                flush = 1'b1;
            end
        end
    end

    // ---------------- stage registers ----------------
    assign stage_next[0] = stall ? BUBBLE : dec;
    assign stage_next[1] = stage_reg[0];
    assign stage_next[2] = stage_reg[1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) stage_reg[i] <= BUBBLE;
            else     stage_reg[i] <= stage_next[i];
        end
    end

    // ---------------- forwarding: operand 0 = rs (A), operand 1 = rt (B) ----------------
    logic [RA_W-1:0] fwd_src [2];
    logic [1:0]      fwd_sel [2];

    assign fwd_src[0] = ex_b.rs;
    assign fwd_src[1] = ex_b.rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = (FWD_EN == 0)                          ? 2'd0 :
                                 (mem_writes && mem_b.dst == fwd_src[gi]) ? 2'd2 :
                                 (wb_writes  && wb_b.dst  == fwd_src[gi]) ? 2'd1 : 2'd0;
        end
    endgenerate

    assign fwdA = fwd_sel[0];
    assign fwdB = fwd_sel[1];

    assign ex_ALUop     = ex_b.alu_op;
    assign ex_ALUsrc    = ex_b.alu_src;
    assign ex_regDest   = ex_b.reg_dest;
    assign illegal      = ex_b.illegal;
    assign mem_memRead  = mem_b.mem_read;
    assign mem_memWrite = mem_b.mem_write;
    assign wb_regWrite  = wb_b.reg_write;
    assign wb_memToReg  = wb_b.mem_to_reg;
    assign wb_dst       = wb_b.dst;

    // Later stages carry the whole bundle; fields a stage does not consume are collected here.
    assign unused_bits = ^{stage_reg[0], stage_reg[1], stage_reg[2]};

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter RA_W, default 5: register-address width for rs, rt, rd and all stored destinations.
REQ-002 Parameter FWD_EN, default 1: 1 enables EX forwarding; 0 forces all fwd selects to 0 and resolves RAW hazards by stalling.
REQ-003 Parameter ADDI_EN, default 1: 1 decodes opcode 6'b001000 as addi; 0 treats it as illegal.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 opcode, func  in  6 each  ID-stage instruction fields.
REQ-007 rs, rt, rd  in  RA_W each  ID-stage register fields.
REQ-008 equal, notEqual  in  1 each  ID-stage comparator results.
REQ-009 stall  out  1  hold PC and IF/ID; combinational.
REQ-010 flush  out  1  clear IF/ID; combinational.
REQ-011 PCsrc  out  2  0 = PC+4, 1 = branch target, 2 = jump target; combinational.
REQ-012 ex_ALUop  out  3, ex_ALUsrc, ex_regDest  out  1 each  EX-stage controls from the ID/EX register.
REQ-013 fwdA, fwdB  out  2 each  EX operand select: 0 = register file, 1 = MEM/WB, 2 = EX/MEM.
REQ-014 mem_memRead, mem_memWrite  out  1 each  MEM-stage controls from the EX/MEM register.
REQ-015 wb_regWrite, wb_memToReg  out  1 each, wb_dst  out  RA_W  WB-stage controls from the MEM/WB register.
REQ-016 illegal  out  1  high while an undecodable instruction occupies EX.

Function
REQ-017 Decode: R-type (opcode 0) ALUop add 0, sub 1, and 2, or 3, slt 4, other func 7 with regWrite 0; lw/sw ALUop 0, ALUsrc 1; addi ALUop 0, ALUsrc 1, regWrite 1; beq/bne/j ALUop 7, no writes.
REQ-018 Destination: rd for R-type, rt for lw/addi; a destination of 0 never counts as a write for hazards or forwarding.
REQ-019 Bundles advance ID/EX -> EX/MEM -> MEM/WB each cycle; latency from ID to WB controls is 3 cycles.
REQ-020 Bubble: ALUop 7 and every enable, dst and illegal bit 0.
REQ-021 Load-use: EX holds lw with dst == rs, or dst == rt for an instruction reading rt (R-type, sw, beq, bne) -> stall 1, ID/EX loads a bubble.
REQ-022 Branch operand hazard: beq/bne source matches a writing EX dst, or a MEM-stage lw dst -> stall 1.
REQ-023 FWD_EN=0: any source match with a writing EX or MEM dst -> stall 1; WB matches need no stall (write-first register file).
REQ-024 Not stalled: taken beq (equal) or bne (notEqual) -> PCsrc 1, flush 1; j -> PCsrc 2, flush 1; else PCsrc 0, flush 0.
REQ-025 Stall has priority: while stall=1, PCsrc 0 and flush 0.
REQ-026 Forwarding (FWD_EN=1) for ex_rs/ex_rt: EX/MEM writer with matching dst -> 2; else MEM/WB writer with matching dst -> 1; else 0. The younger producer wins when both match.
REQ-027 Undecodable opcode: bubble controls with illegal=1 carried into ID/EX; no stall or flush generated.

Reset
REQ-028 rst=1 at a clock edge loads bubbles into all three stage registers; next cycle every registered output is 0 except ex_ALUop=7.
REQ-029 rst mid-stall or mid-branch discards in-flight bundles; stall, flush and PCsrc depend only on ID inputs and the cleared registers.

Verification
REQ-030 Reset: assert rst 1 cycle with lw in pipe -> all registered outputs 0, ex_ALUop=7, illegal=0.
REQ-031 Load-use: lw $2; then add $3,$2,$4 -> stall=1 for exactly 1 cycle, then fwdA=1 when the add is in EX.
REQ-032 Forward priority: add $2; sub $2; or $5,$2,$2 -> fwdA=fwdB=2 for the or.
REQ-033 Branch: beq with equal=1 and no hazard -> PCsrc=1, flush=1; j -> PCsrc=2; beq sourcing an EX-stage add dst -> stall=1, PCsrc=0.
REQ-034 FWD_EN=0: add $2; then sub $3,$2,$1 -> stall 2 cycles, fwdA=fwdB=0 throughout.
REQ-035 Illegal and zero dst: opcode 6'b111111 -> illegal=1 in EX, no writes; add $0 then use $0 -> no stall, fwd=0.
